imm_buffer: RTL
===============

# imm_buffer

Circular immediate buffer (irob) between rename/dispatch and the integer issue queues. Dispatch parks each instruction's 20-bit immediate here and carries only the returned `irobIdx_t` through the dispatch queue and reservation station. Issue reads the immediate back by index one cycle before execute. Entries are freed in order as the ROB retires immediate-using instructions, and all live entries are dropped on a retire-time squash.

## Interface
- `DEPTH`, 32, number of entries; power of two, ≥ 2·ENQ_WIDTH; index width `IW = $clog2(DEPTH)` (= `irobIdx_t`)
- `ENQ_WIDTH`, 4, allocation lanes per cycle (rename width)
- `READ_PORTS`, 2, issue-side read ports
- `COMMIT_WIDTH`, 4, maximum entries freed per cycle
- `IMM_W`, 20, immediate width (`IMMDEF`)

Ports:
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-low reset; all state clears while low
- `i_enq_req`  in  ENQ_WIDTH  per-lane allocate request; may be sparse
- `i_enq_imm`  in  ENQ_WIDTH×IMM_W  per-lane immediate
- `o_can_enq`  out  1  free entries ≥ ENQ_WIDTH
- `o_enq_idx`  out  ENQ_WIDTH×IW  index assigned to each requesting lane
- `i_read_idx`  in  READ_PORTS×IW  issue read index
- `o_read_imm`  out  READ_PORTS×IMM_W  registered read data
- `i_dealloc_num`  in  $clog2(COMMIT_WIDTH+1)  entries retired this cycle
- `i_squash`  in  1  retire-time squash; flush all live entries
- `o_count`  out  $clog2(DEPTH+1)  live entries
- `o_empty`  out  1  count == 0

## Operation
- State:
  - `head` and `tail` pointers, IW+1 bits each; the MSB is the wrap bit.
  - Entry array `mem[DEPTH]` of IMM_W bits.
  - `count` = tail − head, computed modulo 2^(IW+1).
- Allocation:
  - Takes effect only when `o_can_enq` = 1 and `i_squash` = 0. Dispatch must not raise requests otherwise.
  - Lane k receives `o_enq_idx[k]` = (tail + number of set request bits in lanes 0..k−1)[IW−1:0]. This is combinational from `tail` and `i_enq_req`.
  - Non-requesting lanes output the index the next requester would get; the value is don't-care.
  - At the edge, `mem[o_enq_idx[k]] <= i_enq_imm[k]` for each requesting lane, and `tail <= tail + popcount(i_enq_req)`.
- Deallocation: `head <= head + i_dealloc_num`. The ROB guarantees `i_dealloc_num` ≤ `count`.
- Squash: `tail <= head + i_dealloc_num`, i.e. the buffer becomes empty after the same-cycle retire. Same-cycle enqueues are discarded and their indices are not consumed.
- Read: `o_read_imm[p] <= mem[i_read_idx[p]]` every cycle, unconditionally.
- Occupancy: `o_can_enq = (DEPTH − count) ≥ ENQ_WIDTH`; `o_empty = (count == 0)`. Both are combinational from registered state.

## Timing
- Reset values: head = tail = 0, `o_count` = 0, `o_empty` = 1, `o_can_enq` = 1, `o_read_imm` = 0. `mem` contents are not reset.
- Reset asserted mid-operation clears pointers immediately (asynchronously). The first enqueue after release gets index 0.
- Allocation is visible in `o_count` in the cycle after the request edge. Read latency is exactly 1 cycle.
- Simultaneous enq + dealloc: count_next = count + popcount(req) − dealloc_num. Freed entries are usable by `o_can_enq` in the following cycle, never the same cycle.
- Wrap-around: indices roll from DEPTH−1 to 0 within one allocation group. Full vs. empty is distinguished by the wrap bit: count == DEPTH means full, and then `o_can_enq` = 0.
- A read of an index being written in the same cycle is covered by the `IMMBUF_READ_BYPASS_EN` macro (see Configuration).

## Configuration
- `IMMBUF_READ_BYPASS_EN` defined:
  - Each read port compares `i_read_idx[p]` against every requesting lane's `o_enq_idx` when the allocation takes effect.
  - On a match, the port registers that lane's `i_enq_imm`, so it returns the new value the next cycle.
- Undefined: no comparators, and such a read returns the prior contents of `mem`. Dispatch-to-issue spacing of ≥ 1 cycle makes this safe.

## Test plan
- Reset then 4-lane enq with imms 0x1,0x2,0x3,0x4 → `o_enq_idx` = 0,1,2,3; next cycle `o_count` = 4; reading idx 2 returns 0x3 one cycle later.
- Sparse request 4'b1010 with tail = 5 → lane1 gets idx 5, lane3 gets idx 6; tail becomes 7.
- Fill to count = 29 → `o_can_enq` = 0. In the same cycle dealloc 4 → count 25, and `o_can_enq` = 1 the next cycle.
- Tail = 30, enq 4 → indices 30,31,0,1; wrap bit toggles; `o_count` is correct and readback of idx 0 and idx 31 matches.
- count = 10, dealloc 3 + squash + enq 4 same cycle → next cycle `o_count` = 0, `o_empty` = 1, tail = head; the next enq gets idx = old head + 3.
- Read idx 8 on the same edge that enqueues 0xABCDE into idx 8 → with the macro, `o_read_imm` = 0xABCDE; without it, the prior `mem[8]`.

Source files
------------

// File: rtl/imm_buffer.sv
// Circular immediate buffer (irob): dispatch parks immediates, issue reads them back by index.
// Optional same-cycle write-to-read bypass is enabled by defining IMMBUF_READ_BYPASS_EN.
module imm_buffer #(
  parameter int DEPTH        = 32,
  parameter int ENQ_WIDTH    = 4,
  parameter int READ_PORTS   = 2,
  parameter int COMMIT_WIDTH = 4,
  parameter int IMM_W        = 20,
  localparam int IW = $clog2(DEPTH),
  localparam int PW = IW + 1,
  localparam int DW = $clog2(COMMIT_WIDTH + 1),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ENQ_WIDTH-1:0]        i_enq_req,
  input  logic [ENQ_WIDTH*IMM_W-1:0]  i_enq_imm,
  output logic                        o_can_enq,
  output logic [ENQ_WIDTH*IW-1:0]     o_enq_idx,
  input  logic [READ_PORTS*IW-1:0]    i_read_idx,
  output logic [READ_PORTS*IMM_W-1:0] o_read_imm,
  input  logic [DW-1:0]               i_dealloc_num,
  input  logic                        i_squash,
  output logic [CW-1:0]               o_count,
  output logic                        o_empty
);

  // Handshake: i_enq_req may only be raised while o_can_enq is high; an
  // allocation takes effect on the edge where o_can_enq=1 and i_squash=0.

  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [IMM_W-1:0] mem_q [DEPTH];
  logic [IMM_W-1:0] read_q [READ_PORTS];
  logic [IMM_W-1:0] read_d [READ_PORTS];

  logic [PW-1:0]    count;
  logic             can_enq;
  logic             alloc_fire;
  logic [PW-1:0]    enq_cnt;
  logic [IW-1:0]    enq_idx [ENQ_WIDTH];
  logic [IMM_W-1:0] enq_imm [ENQ_WIDTH];
  logic [IW-1:0]    rd_idx  [READ_PORTS];

  // Wrap bit in the MSB keeps full (count==DEPTH) distinct from empty.
  assign count      = tail_q - head_q;
  assign can_enq    = (DEPTH - int'(count)) >= ENQ_WIDTH;
  assign alloc_fire = can_enq && !i_squash;

  assign o_count   = CW'(count);
  assign o_empty   = (count == '0);
  assign o_can_enq = can_enq;

  always_comb begin
    for (int k = 0; k < ENQ_WIDTH; k++) begin
      enq_imm[k] = i_enq_imm[k*IMM_W +: IMM_W];
    end
    for (int p = 0; p < READ_PORTS; p++) begin
      rd_idx[p] = i_read_idx[p*IW +: IW];
    end
  end

  // Lane k gets tail plus the number of requesters in lower lanes.
  always_comb begin
    logic [PW-1:0] ptr;
    enq_cnt   = '0;
    o_enq_idx = '0;
    ptr       = '0;
    for (int k = 0; k < ENQ_WIDTH; k++) begin
      ptr        = tail_q + enq_cnt;
      enq_idx[k] = ptr[IW-1:0];
      o_enq_idx[k*IW +: IW] = ptr[IW-1:0];
      enq_cnt    = enq_cnt + PW'(i_enq_req[k]);
    end
  end

  // Squash empties the buffer after the same-cycle retire and discards enqueues.
  always_comb begin
    head_d = head_q + PW'(i_dealloc_num);
    tail_d = tail_q;
    if (i_squash) begin
      tail_d = head_d;
    end else if (alloc_fire) begin
      tail_d = tail_q + enq_cnt;
    end
  end

  always_comb begin
    for (int p = 0; p < READ_PORTS; p++) begin
      read_d[p] = mem_q[rd_idx[p]];
`ifdef IMMBUF_READ_BYPASS_EN
      for (int k = 0; k < ENQ_WIDTH; k++) begin
        if (alloc_fire && i_enq_req[k] && (enq_idx[k] == rd_idx[p])) begin
          read_d[p] = enq_imm[k];
        end
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q <= '0;
      tail_q <= '0;
      for (int p = 0; p < READ_PORTS; p++) begin
        read_q[p] <= '0;
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      for (int p = 0; p < READ_PORTS; p++) begin
        read_q[p] <= read_d[p];
      end
    end
  end

  // Entry storage is intentionally not reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < ENQ_WIDTH; k++) begin
      if (alloc_fire && i_enq_req[k]) begin
        mem_q[enq_idx[k]] <= enq_imm[k];
      end
    end
  end

  always_comb begin
    o_read_imm = '0;
    for (int p = 0; p < READ_PORTS; p++) begin
      o_read_imm[p*IMM_W +: IMM_W] = read_q[p];
    end
  end

  a_enq_when_room: assert property (@(posedge clk) disable iff (!rst)
    (|i_enq_req) |-> can_enq);
  a_dealloc_le_count: assert property (@(posedge clk) disable iff (!rst)
    PW'(i_dealloc_num) <= count);

endmodule
